// File: rtl/tdm_demux4_pkg.sv
// rtl/tdm_demux4_pkg.sv - shared definitions for the TDM lane link (state encodings, default sizes)
package tdm_demux4_pkg;

  // Receive FSM state encodings
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Default link geometry, shared with the transmit-side mux
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_LANES  = 4;
  localparam int DEF_SLOT_W = 3;

endpackage

// File: rtl/tdm_demux4_slot_dec.sv
// rtl/tdm_demux4_slot_dec.sv - slot index plus enable to one-hot lane write enable
module slot_dec
  import tdm_demux4_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic [SLOT_W-1:0] slot,
  input  logic              en,
  output logic [LANES-1:0]  we
);

  // One-hot decode; out-of-range indices decode to no write at all
  always_comb begin
    we = '0;
    for (int k = 0; k < LANES; k++) begin
      if (en && (slot == SLOT_W'(k))) we[k] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - TDM receive demux: slot-synchronised lane registers plus full-frame snapshot
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LANES  = DEF_LANES,
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic                   i_sof,
  input  logic [WIDTH-1:0]       i_data,
  output logic [LANES*WIDTH-1:0] o_lane,
  output logic [LANES-1:0]       o_lane_we,
  output logic [LANES*WIDTH-1:0] o_frame,
  output logic                   o_frame_done,
  output logic                   o_sync_err,
  output logic                   o_drop,
  output logic                   o_busy
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LANES - 1);

  state_t                   state, state_nxt;
  logic [SLOT_W-1:0]        slot, slot_nxt;
  logic                     slot_bad;
  logic                     wr_en;
  logic [SLOT_W-1:0]        wr_slot;
  logic [LANES-1:0]         wr_we;
  logic                     done_nxt, sync_nxt, drop_nxt;
  logic [LANES*WIDTH-1:0]   lane_nxt;

  // A slot index past the last lane can only come from corruption; recover to IDLE
  assign slot_bad = (slot > LAST_SLOT);

  // State register: FSM state and slot counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // Next-state logic: sof starts/restarts a frame, last slot completes it
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    case (state)
      IDLE: begin
        if (i_valid && i_sof) begin
          state_nxt = RECV;
          slot_nxt  = SLOT_W'(1);
        end else begin
          slot_nxt  = '0;
        end
      end
      RECV: begin
        if (slot_bad) begin
          state_nxt = IDLE;
          slot_nxt  = '0;
        end else if (i_valid) begin
          if (i_sof) begin
            slot_nxt  = SLOT_W'(1);
          end else if (slot == LAST_SLOT) begin
            state_nxt = IDLE;
            slot_nxt  = '0;
          end else begin
            slot_nxt  = slot + SLOT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        slot_nxt  = '0;
      end
    endcase
  end

  // Output decode: lane write target and event pulses for this cycle's word
  always_comb begin
    wr_en    = 1'b0;
    wr_slot  = slot;
    done_nxt = 1'b0;
    sync_nxt = 1'b0;
    drop_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if (i_sof) begin
            wr_en   = 1'b1;
            wr_slot = '0;
          end else begin
            drop_nxt = 1'b1;
          end
        end
      end
      RECV: begin
        if (i_valid && !slot_bad) begin
          wr_en = 1'b1;
          if (i_sof) begin
            wr_slot  = '0;
            sync_nxt = 1'b1;
          end else if (slot == LAST_SLOT) begin
            done_nxt = 1'b1;
          end
        end
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  slot_dec #(
    .LANES  (LANES),
    .SLOT_W (SLOT_W)
  ) u_slot_dec (
    .slot (wr_slot),
    .en   (wr_en),
    .we   (wr_we)
  );

  // Lane vector after this cycle's write; also the snapshot source so the last word is included
  always_comb begin
    lane_nxt = o_lane;
    for (int k = 0; k < LANES; k++) begin
      if (wr_we[k]) lane_nxt[k*WIDTH +: WIDTH] = i_data;
    end
  end

  // Registered outputs; reset also clears the snapshot so no partial frame survives
  always_ff @(posedge clk) begin
    if (reset) begin
      o_lane       <= '0;
      o_lane_we    <= '0;
      o_frame      <= '0;
      o_frame_done <= 1'b0;
      o_sync_err   <= 1'b0;
      o_drop       <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_lane       <= lane_nxt;
      o_lane_we    <= wr_we;
      o_frame_done <= done_nxt;
      o_sync_err   <= sync_nxt;
      o_drop       <= drop_nxt;
      o_busy       <= (state_nxt == RECV);
      if (done_nxt) o_frame <= lane_nxt;
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed table-driven bench for tdm_demux4
module tb_tdm_demux4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        i_sof;
  logic [3:0]  i_data;
  logic [15:0] o_lane;
  logic [3:0]  o_lane_we;
  logic [15:0] o_frame;
  logic        o_frame_done;
  logic        o_sync_err;
  logic        o_drop;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  tdm_demux4 dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .i_sof        (i_sof),
    .i_data       (i_data),
    .o_lane       (o_lane),
    .o_lane_we    (o_lane_we),
    .o_frame      (o_frame),
    .o_frame_done (o_frame_done),
    .o_sync_err   (o_sync_err),
    .o_drop       (o_drop),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        sof;
    logic [3:0]  data;
    logic [15:0] lane;
    logic [3:0]  we;
    logic [15:0] frame;
    logic        done;
    logic        sync;
    logic        drop;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst, input logic valid, input logic sof,
                              input logic [3:0] data, input logic [15:0] lane,
                              input logic [3:0] we, input logic [15:0] frame,
                              input logic done, input logic sync, input logic drop,
                              input logic busy);
    vec_t v;
    v.rst = rst; v.valid = valid; v.sof = sof; v.data = data;
    v.lane = lane; v.we = we; v.frame = frame;
    v.done = done; v.sync = sync; v.drop = drop; v.busy = busy;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d act=%h exp=%h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic valid, input logic sof, input logic [3:0] data);
    reset   = rst;
    i_valid = valid;
    i_sof   = sof;
    i_data  = data;
    @(posedge clk);
    #1;
  endtask

  int done_cnt;
  int err_cnt;
  logic [3:0] gap_words [4];

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_data = 4'h0;

    //  rst v sof data  lane      we       frame     done sync drop busy
    // reset state
    add(1, 0, 0, 4'h0, 16'h0000, 4'b0000, 16'h0000, 0, 0, 0, 0);
    // frame A,B,C,D back to back
    add(0, 1, 1, 4'hA, 16'h000A, 4'b0001, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 0, 4'hB, 16'h00BA, 4'b0010, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 0, 4'hC, 16'h0CBA, 4'b0100, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 0, 4'hD, 16'hDCBA, 4'b1000, 16'hDCBA, 1, 0, 0, 0);
    add(0, 0, 0, 4'h0, 16'hDCBA, 4'b0000, 16'hDCBA, 0, 0, 0, 0);
    // resync: sof 1,2 then sof 7,8,9,A
    add(0, 1, 1, 4'h1, 16'hDCB1, 4'b0001, 16'hDCBA, 0, 0, 0, 1);
    add(0, 1, 0, 4'h2, 16'hDC21, 4'b0010, 16'hDCBA, 0, 0, 0, 1);
    add(0, 1, 1, 4'h7, 16'hDC27, 4'b0001, 16'hDCBA, 0, 1, 0, 1);
    add(0, 1, 0, 4'h8, 16'hDC87, 4'b0010, 16'hDCBA, 0, 0, 0, 1);
    add(0, 1, 0, 4'h9, 16'hD987, 4'b0100, 16'hDCBA, 0, 0, 0, 1);
    add(0, 1, 0, 4'hA, 16'hA987, 4'b1000, 16'hA987, 1, 0, 0, 0);
    // stray word in IDLE is dropped
    add(0, 1, 0, 4'h5, 16'hA987, 4'b0000, 16'hA987, 0, 0, 1, 0);
    add(0, 0, 0, 4'h0, 16'hA987, 4'b0000, 16'hA987, 0, 0, 0, 0);
    // reset mid-frame, then frame 4,3,2,1
    add(0, 1, 1, 4'h1, 16'hA981, 4'b0001, 16'hA987, 0, 0, 0, 1);
    add(0, 1, 0, 4'h2, 16'hA921, 4'b0010, 16'hA987, 0, 0, 0, 1);
    add(1, 1, 0, 4'h3, 16'h0000, 4'b0000, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 1, 4'h4, 16'h0004, 4'b0001, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 0, 4'h3, 16'h0034, 4'b0010, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 0, 4'h2, 16'h0234, 4'b0100, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 0, 4'h1, 16'h1234, 4'b1000, 16'h1234, 1, 0, 0, 0);
    // back-to-back frames 0x4321 then 0x8765, no bubble
    add(0, 1, 1, 4'h1, 16'h1231, 4'b0001, 16'h1234, 0, 0, 0, 1);
    add(0, 1, 0, 4'h2, 16'h1221, 4'b0010, 16'h1234, 0, 0, 0, 1);
    add(0, 1, 0, 4'h3, 16'h1321, 4'b0100, 16'h1234, 0, 0, 0, 1);
    add(0, 1, 0, 4'h4, 16'h4321, 4'b1000, 16'h4321, 1, 0, 0, 0);
    add(0, 1, 1, 4'h5, 16'h4325, 4'b0001, 16'h4321, 0, 0, 0, 1);
    add(0, 1, 0, 4'h6, 16'h4365, 4'b0010, 16'h4321, 0, 0, 0, 1);
    add(0, 1, 0, 4'h7, 16'h4765, 4'b0100, 16'h4321, 0, 0, 0, 1);
    add(0, 1, 0, 4'h8, 16'h8765, 4'b1000, 16'h8765, 1, 0, 0, 0);
    add(0, 0, 0, 4'h0, 16'h8765, 4'b0000, 16'h8765, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].valid, vq[i].sof, vq[i].data);
      chk("lane",     i, 32'(o_lane),       32'(vq[i].lane));
      chk("lane_we",  i, 32'(o_lane_we),    32'(vq[i].we));
      chk("frame",    i, 32'(o_frame),      32'(vq[i].frame));
      chk("done",     i, 32'(o_frame_done), 32'(vq[i].done));
      chk("sync_err", i, 32'(o_sync_err),   32'(vq[i].sync));
      chk("drop",     i, 32'(o_drop),       32'(vq[i].drop));
      chk("busy",     i, 32'(o_busy),       32'(vq[i].busy));
    end

    // Gapped frame: A,B,C,D with 3 idle cycles between words
    gap_words[0] = 4'hA; gap_words[1] = 4'hB; gap_words[2] = 4'hC; gap_words[3] = 4'hD;
    done_cnt = 0;
    err_cnt  = 0;
    for (int w = 0; w < 4; w++) begin
      step(1'b0, 1'b1, (w == 0), gap_words[w]);
      if (o_frame_done) done_cnt++;
      if (o_sync_err || o_drop) err_cnt++;
      if (w < 3) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, 1'b0, 4'hF);
          if (o_frame_done) done_cnt++;
          if (o_sync_err || o_drop) err_cnt++;
          chk("gap_busy", 100 + w * 3 + g, 32'(o_busy), 32'd1);
          chk("gap_we",   100 + w * 3 + g, 32'(o_lane_we), 32'd0);
        end
      end
    end
    chk("gap_frame", 200, 32'(o_frame), 32'hDCBA);
    chk("gap_lane",  201, 32'(o_lane),  32'hDCBA);
    chk("gap_busy_end", 202, 32'(o_busy), 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    if (o_frame_done) done_cnt++;
    chk("gap_done_cnt", 203, 32'(done_cnt), 32'd1);
    chk("gap_err_cnt",  204, 32'(err_cnt),  32'd0);
    chk("gap_frame_hold", 205, 32'(o_frame), 32'hDCBA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
